alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
Iterative multiply/divide unit beside the execute-stage ALU. It adds the MIPS HI/LO register pair and the MULT/MULTU/DIV/DIVU/MTHI/MTLO operations to the integer datapath. Operands come from the ID/EX register. HI/LO are read through o_hi/o_lo for MFHI/MFLO. The hazard unit stalls the pipeline while o_busy is high.

Parameters:
NB_REG, 32, operand/result width (even, >=4)
NB_OP, 3, width of i_op
NB_CNT, $clog2(NB_REG)+1, iteration counter width (derived)

Ports:
i_clock  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_start  in  1  request; sampled only in IDLE
i_op  in  NB_OP  operation code (encoding below)
i_a  in  NB_REG  rs operand / dividend / multiplicand
i_b  in  NB_REG  rt operand / divisor / multiplier
o_busy  out  1  high while iterating (CALC)
o_done  out  1  one-cycle pulse when HI/LO hold a new mul/div result
o_hi  out  NB_REG  HI register
o_lo  out  NB_REG  LO register

Behaviour:
- Reset: asynchronous, active-low. All registered outputs clear while low: state=IDLE, counter=0, o_busy=0, o_done=0, o_hi=0, o_lo=0. Any operation in flight is abandoned and nothing is written.
- Op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
  - 6 and 7 only with the optional feature; otherwise they are no-ops.
- States: IDLE, CALC, FIN.
- IDLE with i_start=1:
  - MTHI: o_hi<=i_a at the next edge. MTLO: o_lo<=i_a at the next edge. State stays IDLE; no busy, no done.
  - No-op codes: nothing is written; state stays IDLE.
  - Mul/div codes: latch operands, op and sign flags; counter<=NB_REG; go to CALC.
- Operand capture (signed ops): latch magnitudes |i_a| and |i_b|, plus result-sign flags. The most negative input has magnitude 2^(NB_REG-1), treated as unsigned.
- CALC:
  - o_busy=1. One iteration per cycle, counter decrements, NB_REG cycles total.
  - Multiply: shift-add, 2*NB_REG-bit product.
  - Divide: restoring, one quotient bit per cycle.
  - On the edge where counter reaches 0: write the sign-corrected result to HI/LO and go to FIN.
- Result mapping:
  - Multiply: {o_hi,o_lo} = full product. MULT is signed; MULTU is unsigned.
  - Divide: o_lo = quotient, o_hi = remainder.
  - Signed divide: quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend (truncation toward zero).
- FIN: o_done=1, o_busy=0, new HI/LO visible. Go to IDLE at the next edge. i_start is ignored in FIN.
- Latency: start sampled at edge E0 → o_busy high for cycles 1..NB_REG → o_done high in cycle NB_REG+1. The next request is accepted at edge E0+NB_REG+2.
- i_start while o_busy or o_done is high: ignored. Operands and op in flight are unaffected by input changes after E0.
- Divide by zero: o_lo = all ones, o_hi = i_a as supplied, for both signed and unsigned. Latency is unchanged and o_done still pulses.
- Signed overflow (-2^(NB_REG-1) / -1): o_lo = -2^(NB_REG-1), o_hi = 0.
- o_hi/o_lo change only at the final CALC edge, on MTHI/MTLO, or on reset. MFHI/MFLO reads during CALC return the old values.

Optional Feature:
Macro ALU_MULDIV_MADD_EN.
- Defined: ops 6 (MADD, signed) and 7 (MADDU) are legal. They run exactly like MULT/MULTU. At the final edge, {o_hi,o_lo} <= {o_hi,o_lo} + product, modulo 2^(2*NB_REG), with the old HI/LO sampled at that edge. Latency is unchanged.
- Not defined: ops 6 and 7 are no-ops. No state change, no write, no o_done. The accumulator logic is not synthesised.

Test Plan:
- Reset low mid-CALC of MULT 5*5 → o_busy=0, o_done=0, o_hi=o_lo=0 at once; after release, no o_done pulse and HI/LO stay 0.
- MULT a=FFFFFFFD(-3), b=7 → o_done in cycle 33; o_hi=FFFFFFFF, o_lo=FFFFFFEB. MULTU a=FFFFFFFF, b=2 → o_hi=00000001, o_lo=FFFFFFFE.
- DIV a=FFFFFFF9(-7), b=2 → o_lo=FFFFFFFD, o_hi=FFFFFFFF. DIV 80000000/FFFFFFFF → o_lo=80000000, o_hi=0.
- DIVU a=5, b=0 → o_lo=FFFFFFFF, o_hi=00000005, o_done still in cycle 33.
- MULT 3*4 started; i_start with DIVU 9/3 at cycle 10 and again in the FIN cycle → both ignored; o_hi=0, o_lo=0000000C. MTHI i_a=1234 in the next IDLE → o_hi=1234 one edge later, no o_done.
- With ALU_MULDIV_MADD_EN: MTLO 10, MTHI 0, then MADD 3*FFFFFFFF(-1) → o_hi=0, o_lo=7. Without the macro: same sequence leaves o_lo=10, o_busy stays 0.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative MIPS HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Define ALU_MULDIV_MADD_EN to enable MADD/MADDU (codes 6/7) accumulating into HI/LO.
module alu_muldiv #(
  parameter int NB_REG = 32,
  parameter int NB_OP  = 3,
  parameter int NB_CNT = $clog2(NB_REG) + 1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [NB_OP-1:0]  i_op,
  input  logic [NB_REG-1:0] i_a,
  input  logic [NB_REG-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [NB_REG-1:0] o_hi,
  output logic [NB_REG-1:0] o_lo
);
  localparam logic [NB_OP-1:0] OP_MULT  = NB_OP'(0);
  localparam logic [NB_OP-1:0] OP_MULTU = NB_OP'(1);
  localparam logic [NB_OP-1:0] OP_DIV   = NB_OP'(2);
  localparam logic [NB_OP-1:0] OP_DIVU  = NB_OP'(3);
  localparam logic [NB_OP-1:0] OP_MTHI  = NB_OP'(4);
  localparam logic [NB_OP-1:0] OP_MTLO  = NB_OP'(5);
  localparam logic [NB_OP-1:0] OP_MADD  = NB_OP'(6);
`ifdef ALU_MULDIV_MADD_EN
  localparam logic [NB_OP-1:0] OP_MADDU = NB_OP'(7);
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  typedef struct packed {
    logic is_mul;
    logic is_madd;
    logic neg_res;   // product / quotient negated at the end
    logic sign_a;    // dividend sign: remainder sign and div-by-zero HI
    logic div0;
  } ctl_t;

  state_t              state;
  ctl_t                ctl;
  logic [NB_CNT-1:0]   cnt;
  logic [NB_REG-1:0]   mag_a, mag_b;
  logic [2*NB_REG-1:0] work;   // mul: {partial, multiplier}; div: {remainder, dividend/quotient}

  logic              op_mul, op_div, op_sgn, op_madd;
  logic              sa, sb;
  logic [NB_REG-1:0] abs_a, abs_b;

  always_comb begin
    op_madd = 1'b0;
`ifdef ALU_MULDIV_MADD_EN
    op_madd = (i_op == OP_MADD) || (i_op == OP_MADDU);
`endif
    op_mul = (i_op == OP_MULT) || (i_op == OP_MULTU) || op_madd;
    op_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
    op_sgn = (i_op == OP_MULT) || (i_op == OP_DIV) || (i_op == OP_MADD);
    sa     = op_sgn & i_a[NB_REG-1];
    sb     = op_sgn & i_b[NB_REG-1];
    // -(-2^(N-1)) wraps to 2^(N-1), which is the right unsigned magnitude
    abs_a  = sa ? -i_a : i_a;
    abs_b  = sb ? -i_b : i_b;
  end

  logic [NB_REG:0]     add_sum, r_shift, r_diff;
  logic [2*NB_REG-1:0] work_nxt, mul_res, res;
  logic [NB_REG-1:0]   quo, rem, a_orig;

  always_comb begin
    add_sum = {1'b0, work[2*NB_REG-1:NB_REG]} + {1'b0, mag_a & {NB_REG{work[0]}}};
    r_shift = {work[2*NB_REG-1:NB_REG], work[NB_REG-1]};
    r_diff  = r_shift - {1'b0, mag_b};
    if (ctl.is_mul)
      work_nxt = {add_sum, work[NB_REG-1:1]};
    else if (!r_diff[NB_REG])
      work_nxt = {r_diff[NB_REG-1:0], work[NB_REG-2:0], 1'b1};
    else
      work_nxt = {r_shift[NB_REG-1:0], work[NB_REG-2:0], 1'b0};

    mul_res = ctl.neg_res ? -work_nxt : work_nxt;
    quo     = work_nxt[NB_REG-1:0];
    rem     = work_nxt[2*NB_REG-1:NB_REG];
    a_orig  = ctl.sign_a ? -mag_a : mag_a;

    if (ctl.is_mul) begin
`ifdef ALU_MULDIV_MADD_EN
      res = ctl.is_madd ? ({o_hi, o_lo} + mul_res) : mul_res;
`else
      res = mul_res;
`endif
    end else if (ctl.div0) begin
      res = {a_orig, {NB_REG{1'b1}}};
    end else begin
      res = {(ctl.sign_a ? -rem : rem), (ctl.neg_res ? -quo : quo)};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      ctl    <= '0;
      cnt    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      work   <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_hi   <= '0;
      o_lo   <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          if (i_op == OP_MTHI) begin
            o_hi <= i_a;
          end else if (i_op == OP_MTLO) begin
            o_lo <= i_a;
          end else if (op_mul || op_div) begin
            ctl.is_mul  <= op_mul;
            ctl.is_madd <= op_madd;
            ctl.neg_res <= sa ^ sb;
            ctl.sign_a  <= sa;
            ctl.div0    <= (i_b == '0);
            mag_a       <= abs_a;
            mag_b       <= abs_b;
            work        <= {{NB_REG{1'b0}}, (op_mul ? abs_b : abs_a)};
            cnt         <= NB_CNT'(NB_REG);
            o_busy      <= 1'b1;
            state       <= CALC;
          end
        end
        CALC: begin
          work <= work_nxt;
          cnt  <= cnt - NB_CNT'(1);
          if (cnt == NB_CNT'(1)) begin
            {o_hi, o_lo} <= res;
            o_busy       <= 1'b0;
            o_done       <= 1'b1;
            state        <= FIN;
          end
        end
        FIN: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors plus a per-cycle arithmetic reference model of HI/LO and handshake.
`timescale 1ns/1ps
module tb_alu_muldiv;
  localparam int N = 32;

  logic        clk = 1'b0, rst_n = 1'b0, i_start = 1'b0;
  logic [2:0]  i_op = '0;
  logic [31:0] i_a = '0, i_b = '0;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;
  int          n_cmp = 0, n_bad = 0;
  bit          cmp_en = 1'b0;

  always #5 clk = ~clk;

  alu_muldiv dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(i_start), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic, timing from the stated latency.
  function automatic bit is_muldiv(input logic [2:0] op);
`ifdef ALU_MULDIV_MADD_EN
    return (op < 3'd4) || (op >= 3'd6);
`else
    return op < 3'd4;
`endif
  endfunction

  function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] hl);
    longint      sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            else return {32'(sa % sb), 32'(sa / sb)};
      3'd3: if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            else return {32'(ua % ub), 32'(ua / ub)};
      3'd6: return hl + 64'(sa * sb);
      3'd7: return hl + ua * ub;
      default: return hl;
    endcase
  endfunction

  logic        m_busy, m_done;
  int          m_left;
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [2:0]  m_op;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_hi <= '0; m_lo <= '0;
      m_a <= '0; m_b <= '0; m_op <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        {m_hi, m_lo} <= ref_calc(m_op, m_a, m_b, {m_hi, m_lo});
      end
    end else if (i_start) begin
      if (i_op == 3'd4) m_hi <= i_a;
      else if (i_op == 3'd5) m_lo <= i_a;
      else if (is_muldiv(i_op)) begin
        m_busy <= 1'b1; m_left <= N; m_op <= i_op; m_a <= i_a; m_b <= i_b;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", 64'(o_busy), 64'(m_busy));
      chk("cyc_done", 64'(o_done), 64'(m_done));
      chk("cyc_hi", 64'(o_hi), 64'(m_hi));
      chk("cyc_lo", 64'(o_lo), 64'(m_lo));
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); #1;
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    @(negedge clk); #1;
    i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
  endtask

  // Entered in cycle 1 after the start edge; returns in the o_done cycle.
  task automatic wait_done(output int lat);
    lat = 1;
    while (o_done !== 1'b1 && lat < 100) begin
      @(negedge clk); #1;
      lat++;
    end
    if (o_done !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: o_done never rose within %0d cycles", lat);
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    issue(op, a, b);
    wait_done(lat);
    chk({name, "_lat"}, 64'(lat), 64'd33);
    chk({name, "_hi"}, 64'(o_hi), 64'(ehi));
    chk({name, "_lo"}, 64'(o_lo), 64'(elo));
  endtask

  initial begin
    int lat, pulses;
    repeat (2) @(negedge clk);
    #1 cmp_en = 1'b1;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_hilo", {o_hi, o_lo}, 64'd0);
    rst_n = 1'b1;

    // reset in the middle of an iteration abandons it
    issue(3'd4, 32'h55, 32'h0);
    issue(3'd5, 32'h66, 32'h0);
    chk("mt_hilo", {o_hi, o_lo}, 64'h00000055_00000066);
    issue(3'd0, 32'd5, 32'd5);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_done", 64'(o_done), 64'd0);
    chk("midrst_hilo", {o_hi, o_lo}, 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (o_done === 1'b1) pulses++;
    end
    chk("midrst_no_done", 64'(pulses), 64'd0);
    chk("midrst_hilo_after", {o_hi, o_lo}, 64'd0);

    run("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("multu",     3'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE);
    run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mult_min",  3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_negb",  3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run("divu_zero", 3'd3, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF);
    run("div_zero",  3'd2, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run("divu",      3'd3, 32'd100,       32'd7,        32'd2,         32'd14);

    // starts while busy and in FIN are ignored
    issue(3'd0, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    #1; i_start = 1'b1; i_op = 3'd3; i_a = 32'd9; i_b = 32'd3;
    @(negedge clk); #1; i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    wait_done(lat);
    i_start = 1'b1; i_op = 3'd3; i_a = 32'd9; i_b = 32'd3;
    @(negedge clk); #1; i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    chk("ign_busy", 64'(o_busy), 64'd0);
    chk("ign_hilo", {o_hi, o_lo}, 64'h00000000_0000000C);
    #1; i_start = 1'b1; i_op = 3'd4; i_a = 32'h1234;
    @(negedge clk); #1; i_start = 1'b0; i_op = '0; i_a = '0;
    chk("mthi_hi", 64'(o_hi), 64'h1234);
    chk("mthi_done", 64'(o_done), 64'd0);

    issue(3'd5, 32'd10, 32'd0);
    issue(3'd4, 32'd0, 32'd0);
`ifdef ALU_MULDIV_MADD_EN
    run("madd",  3'd6, 32'd3,         32'hFFFF_FFFF, 32'd0, 32'd7);
    run("maddu", 3'd7, 32'hFFFF_FFFF, 32'd2,         32'd2, 32'd5);
`else
    issue(3'd6, 32'd3, 32'hFFFF_FFFF);
    chk("madd_off_busy", 64'(o_busy), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("madd_off_done", 64'(o_done), 64'd0);
    chk("madd_off_hilo", {o_hi, o_lo}, 64'd10);
`endif

    repeat (2) @(negedge clk);
    #1 cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
